// File: rtl/gshare_predictor_if.sv
// Lookup and resolve bus between the fetch/EX pipeline (master) and the gshare predictor (slave).
// The IF stage drives the lookup signals. EX drives the update signals with the index and history carried from lookup.
interface gshare_predictor_if #(
   parameter int IDX_BITS  = 10,
   parameter int HIST_BITS = 10
);
   logic                 lookup_valid;
   logic [31:0]          lookup_pc;
   logic                 pred_taken;
   logic [IDX_BITS-1:0]  pred_idx;
   logic [HIST_BITS-1:0] pred_ghr;
   logic                 upd_valid;
   logic [IDX_BITS-1:0]  upd_idx;
   logic [HIST_BITS-1:0] upd_ghr;
   logic                 upd_taken;
   logic                 upd_mispredict;

   modport master (
      output lookup_valid, lookup_pc,
      output upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict,
      input  pred_taken, pred_idx, pred_ghr
   );

   modport slave (
      input  lookup_valid, lookup_pc,
      input  upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict,
      output pred_taken, pred_idx, pred_ghr
   );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: a 2-bit counter PHT indexed by PC ^ GHR, with a speculative GHR.
// The GHR is repaired from the carried checkpoint when EX reports a mispredict.
module gshare_predictor #(
   parameter int IDX_BITS  = 10,
   parameter int HIST_BITS = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   gshare_predictor_if.slave    bus,
   output logic                 ready_o,
   output logic [HIST_BITS-1:0] ghr_o
);

   localparam int unsigned PHT_DEPTH = 1 << IDX_BITS;

   typedef enum logic {INIT, RUN} state_e;

   state_e               state_q, state_d;
   logic [IDX_BITS-1:0]  init_ptr_q, init_ptr_d;
   logic [HIST_BITS-1:0] ghr_q, ghr_d;
   logic [1:0]           pht_q [PHT_DEPTH];

   logic                 run;
   logic                 lookup_en;
   logic                 upd_en;
   logic [IDX_BITS-1:0]  lookup_idx;
   logic                 pred_taken;
   logic [1:0]           upd_ctr;
   logic                 pht_we;
   logic [IDX_BITS-1:0]  pht_waddr;
   logic [1:0]           pht_wdata;

   // A strobe that is X or Z counts as idle, so an unknown valid never alters state.
   assign run       = (state_q == RUN);
   assign lookup_en = run && (bus.lookup_valid === 1'b1);
   assign upd_en    = run && (bus.upd_valid === 1'b1);

   assign lookup_idx = bus.lookup_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
   assign pred_taken = run && pht_q[lookup_idx][1];
   assign upd_ctr    = pht_q[bus.upd_idx];

   assign bus.pred_idx   = lookup_idx;
   assign bus.pred_ghr   = ghr_q;
   assign bus.pred_taken = pred_taken;
   assign ready_o        = run;
   assign ghr_o          = ghr_q;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      ghr_d      = ghr_q;
      pht_we     = 1'b0;
      pht_waddr  = init_ptr_q;
      pht_wdata  = 2'b01;

      case (state_q)
         INIT: begin
            pht_we     = 1'b1;
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == '1) state_d = RUN;
         end
         RUN: begin
            if (upd_en) begin
               pht_we    = 1'b1;
               pht_waddr = bus.upd_idx;
               if (bus.upd_taken) pht_wdata = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
               else               pht_wdata = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
            end
            // A mispredict drops any same-cycle lookup shift, because that lookup is on the wrong path.
            if (upd_en && bus.upd_mispredict)
               ghr_d = {bus.upd_ghr[HIST_BITS-2:0], bus.upd_taken};
            else if (lookup_en)
               ghr_d = {ghr_q[HIST_BITS-2:0], pred_taken};
         end
         default: state_d = INIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= INIT;
         init_ptr_q <= '0;
         ghr_q      <= '0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
         ghr_q      <= ghr_d;
      end
   end

   // NOTE: the PHT has no reset so it can map onto RAM; the INIT sweep gives it a known value.
   always_ff @(posedge clk) begin
      if (pht_we) pht_q[pht_waddr] <= pht_wdata;
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor.
// Covers the init sweep and its restart, a vector table (saturation, history, repair, bypass, X strobes) and reset in RUN.
module tb_gshare_predictor;

   logic       clk = 1'b0;
   logic       rst;
   logic       ready;
   logic [9:0] ghr;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int junk_bad = 0;

   always #5 clk = ~clk;

   gshare_predictor_if #(.IDX_BITS(10), .HIST_BITS(10)) bus ();

   gshare_predictor #(.IDX_BITS(10), .HIST_BITS(10)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .ready_o (ready),
      .ghr_o   (ghr)
   );

   typedef struct {
      logic        lv;
      logic [31:0] pc;
      logic        uv;
      logic [9:0]  uidx;
      logic [9:0]  ughr;
      logic        ut;
      logic        um;
      logic        e_pt;
      logic [9:0]  e_idx;
      logic [9:0]  e_ghr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle();
      bus.lookup_valid   = 1'b0;
      bus.lookup_pc      = '0;
      bus.upd_valid      = 1'b0;
      bus.upd_idx        = '0;
      bus.upd_ghr        = '0;
      bus.upd_taken      = 1'b0;
      bus.upd_mispredict = 1'b0;
   endtask

   // Counts clock edges until ready rises, optionally hammering the bus with traffic that INIT must ignore.
   task automatic wait_ready(input bit junk, output int n);
      n = 0;
      while (ready !== 1'b1 && n < 2000) begin
         if (junk) begin
            bus.lookup_valid   = 1'b1;
            bus.lookup_pc      = $urandom;
            bus.upd_valid      = 1'b1;
            bus.upd_idx        = 10'($urandom);
            bus.upd_ghr        = 10'($urandom);
            bus.upd_taken      = 1'($urandom);
            bus.upd_mispredict = 1'b1;
            #1;
            if (bus.pred_taken !== 1'b0) junk_bad++;
         end
         @(posedge clk);
         #1;
         n++;
         if (ghr !== 10'd0) junk_bad++;
      end
      idle();
   endtask

   function automatic vec_t mk(logic lv, logic [31:0] pc, logic uv, logic [9:0] uidx, logic [9:0] ughr,
                               logic ut, logic um, logic e_pt, logic [9:0] e_idx, logic [9:0] e_ghr);
      vec_t v;
      v.lv = lv;  v.pc = pc;  v.uv = uv;  v.uidx = uidx;  v.ughr = ughr;
      v.ut = ut;  v.um = um;  v.e_pt = e_pt;  v.e_idx = e_idx;  v.e_ghr = e_ghr;
      return v;
   endfunction

   initial begin
      int n;
      int bad;

      //          lv    pc        uv    uidx    ughr    ut    um    e_pt  e_idx   e_ghr
      vecs.push_back(mk(1'b0, 32'h10,  1'b1, 10'd4,   10'h0,   1'b1, 1'b0, 1'b0, 10'd4,   10'h0));
      vecs.push_back(mk(1'b0, 32'h10,  1'b1, 10'd4,   10'h0,   1'b1, 1'b0, 1'b1, 10'd4,   10'h0));
      vecs.push_back(mk(1'b0, 32'h10,  1'b1, 10'd4,   10'h0,   1'b1, 1'b0, 1'b1, 10'd4,   10'h0));
      vecs.push_back(mk(1'b0, 32'h10,  1'b1, 10'd4,   10'h0,   1'b0, 1'b0, 1'b1, 10'd4,   10'h0));
      vecs.push_back(mk(1'b0, 32'h10,  1'b1, 10'd4,   10'h0,   1'b0, 1'b0, 1'b1, 10'd4,   10'h0));
      vecs.push_back(mk(1'b0, 32'h10,  1'b1, 10'd4,   10'h0,   1'b0, 1'b0, 1'b0, 10'd4,   10'h0));
      vecs.push_back(mk(1'b0, 32'h10,  1'b1, 10'd4,   10'h0,   1'b0, 1'b0, 1'b0, 10'd4,   10'h0));
      vecs.push_back(mk(1'b0, 32'h10,  1'b1, 10'd4,   10'h0,   1'b1, 1'b0, 1'b0, 10'd4,   10'h0));
      vecs.push_back(mk(1'b0, 32'h10,  1'b1, 10'd4,   10'h0,   1'b1, 1'b0, 1'b0, 10'd4,   10'h0));
      vecs.push_back(mk(1'b0, 32'h10,  1'b0, 10'd0,   10'h0,   1'b0, 1'b0, 1'b1, 10'd4,   10'h0));
      // Same-index lookup and train: old counter seen now, new one next cycle.
      vecs.push_back(mk(1'b1, 32'h1C,  1'b1, 10'd7,   10'h0,   1'b1, 1'b0, 1'b0, 10'd7,   10'h0));
      vecs.push_back(mk(1'b1, 32'h1C,  1'b0, 10'd0,   10'h0,   1'b0, 1'b0, 1'b1, 10'd7,   10'h0));
      // Speculative shifts of predictions 1,0,1 yield ghr=5, so pc 0x10 maps to idx 1.
      vecs.push_back(mk(1'b1, 32'h00,  1'b0, 10'd0,   10'h0,   1'b0, 1'b0, 1'b0, 10'd1,   10'h1));
      vecs.push_back(mk(1'b1, 32'h18,  1'b0, 10'd0,   10'h0,   1'b0, 1'b0, 1'b1, 10'd4,   10'h2));
      vecs.push_back(mk(1'b0, 32'h10,  1'b0, 10'd0,   10'h0,   1'b0, 1'b0, 1'b0, 10'd1,   10'h5));
      // Repair to 0x2AA, then the 0x0F0/taken repair under a concurrent lookup.
      vecs.push_back(mk(1'b1, 32'h10,  1'b1, 10'd100, 10'h155, 1'b0, 1'b1, 1'b0, 10'd1,   10'h5));
      vecs.push_back(mk(1'b1, 32'h10,  1'b1, 10'd200, 10'h0F0, 1'b1, 1'b1, 1'b0, 10'h2AE, 10'h2AA));
      vecs.push_back(mk(1'b0, 32'h00,  1'b1, 10'd200, 10'h0,   1'b1, 1'b0, 1'b0, 10'h1E1, 10'h1E1));
      vecs.push_back(mk(1'b1, 32'h4A4, 1'b0, 10'd0,   10'h0,   1'b0, 1'b0, 1'b1, 10'h0C8, 10'h1E1));
      // Unknown strobes must neither shift, repair nor train.
      vecs.push_back(mk(1'bx, 32'h00,  1'bx, 10'd4,   10'h0,   1'b0, 1'b1, 1'b0, 10'h3C3, 10'h3C3));
      vecs.push_back(mk(1'b0, 32'hF1C, 1'b0, 10'd0,   10'h0,   1'b0, 1'b0, 1'b1, 10'd4,   10'h3C3));

      idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_ready", 32'(ready), 32'd0);
      check("reset_ghr", 32'(ghr), 32'd0);
      check("reset_pred", 32'(bus.pred_taken), 32'd0);

      // Sweep interrupted at cycle 500, then restarted under ignored traffic.
      rst = 1'b0;
      repeat (500) @(posedge clk);
      #1;
      check("sweep500_ready", 32'(ready), 32'd0);
      rst = 1'b1;
      #1;
      check("midsweep_rst_ready", 32'(ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_ready(1'b1, n);
      check("sweep_len", 32'(n), 32'd1024);
      check("init_ignore_bad", 32'(junk_bad), 32'd0);
      check("ready_up", 32'(ready), 32'd1);
      check("ghr_after_init", 32'(ghr), 32'd0);

      bad = 0;
      for (int i = 0; i < 1024; i++) begin
         bus.lookup_pc = 32'(i) << 2;
         #1;
         if (bus.pred_taken !== 1'b0 || bus.pred_idx !== 10'(i)) bad++;
      end
      check("scan_all_weak_nt", 32'(bad), 32'd0);
      idle();

      foreach (vecs[k]) begin
         @(negedge clk);
         bus.lookup_valid   = vecs[k].lv;
         bus.lookup_pc      = vecs[k].pc;
         bus.upd_valid      = vecs[k].uv;
         bus.upd_idx        = vecs[k].uidx;
         bus.upd_ghr        = vecs[k].ughr;
         bus.upd_taken      = vecs[k].ut;
         bus.upd_mispredict = vecs[k].um;
         #1;
         check($sformatf("v%0d_pred_taken", k), 32'(bus.pred_taken), 32'(vecs[k].e_pt));
         check($sformatf("v%0d_pred_idx", k), 32'(bus.pred_idx), 32'(vecs[k].e_idx));
         check($sformatf("v%0d_ghr", k), 32'(ghr), 32'(vecs[k].e_ghr));
         check($sformatf("v%0d_pred_ghr", k), 32'(bus.pred_ghr), 32'(vecs[k].e_ghr));
      end
      @(negedge clk);
      idle();

      // Reset in RUN re-sweeps and clears trained counters (idx 4 and 200 were taken-biased).
      rst = 1'b1;
      #1;
      check("run_rst_ready", 32'(ready), 32'd0);
      check("run_rst_ghr", 32'(ghr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_ready(1'b0, n);
      check("resweep_len", 32'(n), 32'd1024);
      bus.lookup_pc = 32'h10;
      #1;
      check("resweep_idx4", 32'(bus.pred_taken), 32'd0);
      bus.lookup_pc = 32'h320;
      #1;
      check("resweep_idx200", 32'(bus.pred_taken), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
